// File: rtl/mule_issue_arbiter.sv
// ---------------------------------------------------------------------------
// mule_issue_arbiter
//
// Purpose:
//    Shares the single multi-cycle MULE execution unit between the two issue
//    pipes. Grants one request at a time in round-robin order, captures the
//    operands, and drives the unit start handshake. It then waits for
//    completion and returns the result to writeback, together with the
//    destination register and the originating pipe. The block also handles
//    pipeline flush and a completion watchdog.
//
// Parameters:
//    TIMEOUT_CYCLES  cycles spent in WAIT/DRAIN without mule_done_i before
//                    the operation is aborted.
//
// Optional feature:
//    MULE_ARB_PERF_EN  when defined, instantiates the completed-op and
//                      busy-cycle counters. When undefined, both perf
//                      outputs are tied to 0.
//
// Ports:
//    clk_i, rst_i                    clock, synchronous active-high reset
//    req{0,1}_valid_i/ra_i/rb_i/rd_idx_i   per-pipe request
//    req{0,1}_accept_o               request taken this cycle (combinational)
//    flush_i                         discard pending / in-flight operation
//    mule_valid_o/ra_o/rb_o          start request + latched operands
//    mule_accept_i                   unit accepted start
//    mule_done_i/value_i             one-cycle completion pulse + result
//    wb_valid_o/pipe_o/rd_idx_o/value_o    writeback pulse and payload
//    busy_o                          state != IDLE
//    error_o                         one-cycle pulse on watchdog abort
//    perf_ops_o, perf_cycles_o       performance counters
// ---------------------------------------------------------------------------
module mule_issue_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req0_valid_i,
   input  logic [31:0] req0_ra_i,
   input  logic [31:0] req0_rb_i,
   input  logic [4:0]  req0_rd_idx_i,
   output logic        req0_accept_o,
   input  logic        req1_valid_i,
   input  logic [31:0] req1_ra_i,
   input  logic [31:0] req1_rb_i,
   input  logic [4:0]  req1_rd_idx_i,
   output logic        req1_accept_o,
   input  logic        flush_i,
   output logic        mule_valid_o,
   output logic [31:0] mule_ra_o,
   output logic [31:0] mule_rb_o,
   input  logic        mule_accept_i,
   input  logic        mule_done_i,
   input  logic [31:0] mule_value_i,
   output logic        wb_valid_o,
   output logic        wb_pipe_o,
   output logic [4:0]  wb_rd_idx_o,
   output logic [31:0] wb_value_o,
   output logic        busy_o,
   output logic        error_o,
   output logic [31:0] perf_ops_o,
   output logic [31:0] perf_cycles_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic [31:0] ra_q, ra_d;
   logic [31:0] rb_q, rb_d;
   logic [4:0]  rd_q, rd_d;
   logic        pipe_q, pipe_d;
   logic        mule_valid_q, mule_valid_d;
   logic [31:0] wd_q, wd_d;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_pipe_q, wb_pipe_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_value_q, wb_value_d;
   logic        error_q, error_d;

   logic        grant_any;
   logic        grant_pipe;
   logic [31:0] wd_inc;
   logic        wd_expire;

   // Arbitration: with both pipes requesting, the pipe not granted last
   // wins. With one pipe requesting, that pipe wins.
   always_comb begin
      grant_any  = (state_q == S_IDLE) && !flush_i && (req0_valid_i || req1_valid_i);
      grant_pipe = (req0_valid_i && req1_valid_i) ? ~last_q : req1_valid_i;
   end

   assign req0_accept_o = grant_any && !grant_pipe;
   assign req1_accept_o = grant_any &&  grant_pipe;

   // The abort fires on the cycle whose increment would reach the limit.
   // As a result, error_o appears exactly TIMEOUT_CYCLES cycles after WAIT entry.
   assign wd_inc    = wd_q + 32'd1;
   assign wd_expire = (wd_inc == TIMEOUT_W);

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      ra_d       = ra_q;
      rb_d       = rb_q;
      rd_d       = rd_q;
      pipe_d     = pipe_q;
      wd_d       = 32'd0;
      wb_valid_d = 1'b0;
      wb_pipe_d  = wb_pipe_q;
      wb_rd_d    = wb_rd_q;
      wb_value_d = wb_value_q;
      error_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (grant_any) begin
               ra_d    = grant_pipe ? req1_ra_i     : req0_ra_i;
               rb_d    = grant_pipe ? req1_rb_i     : req0_rb_i;
               rd_d    = grant_pipe ? req1_rd_idx_i : req0_rd_idx_i;
               pipe_d  = grant_pipe;
               last_d  = grant_pipe;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // A flush here cancels the operation before the unit has taken
            // it. The flush wins even if the unit accepts in the same cycle.
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (mule_accept_i) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            wd_d = wd_inc;
            if (mule_done_i && flush_i) begin
               state_d = S_IDLE;
            end else if (mule_done_i) begin
               wb_valid_d = 1'b1;
               wb_pipe_d  = pipe_q;
               wb_rd_d    = rd_q;
               wb_value_d = mule_value_i;
               state_d    = S_IDLE;
            end else if (wd_expire) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else if (flush_i) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // The unit is still busy with a flushed op. Swallow its result.
            wd_d = wd_inc;
            if (mule_done_i) begin
               state_d = S_IDLE;
            end else if (wd_expire) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      mule_valid_d = (state_d == S_ISSUE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         last_q       <= 1'b1;
         ra_q         <= 32'd0;
         rb_q         <= 32'd0;
         rd_q         <= 5'd0;
         pipe_q       <= 1'b0;
         mule_valid_q <= 1'b0;
         wd_q         <= 32'd0;
         wb_valid_q   <= 1'b0;
         wb_pipe_q    <= 1'b0;
         wb_rd_q      <= 5'd0;
         wb_value_q   <= 32'd0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         ra_q         <= ra_d;
         rb_q         <= rb_d;
         rd_q         <= rd_d;
         pipe_q       <= pipe_d;
         mule_valid_q <= mule_valid_d;
         wd_q         <= wd_d;
         wb_valid_q   <= wb_valid_d;
         wb_pipe_q    <= wb_pipe_d;
         wb_rd_q      <= wb_rd_d;
         wb_value_q   <= wb_value_d;
         error_q      <= error_d;
      end
   end

   assign mule_valid_o = mule_valid_q;
   assign mule_ra_o    = ra_q;
   assign mule_rb_o    = rb_q;
   assign wb_valid_o   = wb_valid_q;
   assign wb_pipe_o    = wb_pipe_q;
   assign wb_rd_idx_o  = wb_rd_q;
   assign wb_value_o   = wb_value_q;
   assign busy_o       = (state_q != S_IDLE);
   assign error_o      = error_q;

`ifdef MULE_ARB_PERF_EN
   logic [31:0] perf_ops_q, perf_ops_d;
   logic [31:0] perf_cycles_q, perf_cycles_d;

   // Both counters wrap naturally at 2^32.
   always_comb begin
      perf_ops_d    = perf_ops_q    + {31'd0, wb_valid_q};
      perf_cycles_d = perf_cycles_q + {31'd0, busy_o};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_ops_q    <= 32'd0;
         perf_cycles_q <= 32'd0;
      end else begin
         perf_ops_q    <= perf_ops_d;
         perf_cycles_q <= perf_cycles_d;
      end
   end

   assign perf_ops_o    = perf_ops_q;
   assign perf_cycles_o = perf_cycles_q;
`else
   assign perf_ops_o    = 32'd0;
   assign perf_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_mule_issue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mule_issue_arbiter
//
// Directed testbench for mule_issue_arbiter (TIMEOUT_CYCLES = 8).
// A table of single-operation records covers grant order, operand/rd
// routing, backpressure and latency. Hand-written sequences cover flush,
// watchdog, reset, and back-to-back operation with perf counters.
// Build with MULE_ARB_PERF_EN defined to check the counter values. Without
// it, the bench expects the counters to stay at zero.
// ---------------------------------------------------------------------------
module tb_mule_issue_arbiter;

   logic        clk;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_ra, req0_rb, req1_ra, req1_rb;
   logic [4:0]  req0_rd, req1_rd;
   logic        req0_accept, req1_accept;
   logic        flush;
   logic        mule_valid;
   logic [31:0] mule_ra, mule_rb;
   logic        mule_accept, mule_done;
   logic [31:0] mule_value;
   logic        wb_valid, wb_pipe;
   logic [4:0]  wb_rd;
   logic [31:0] wb_value;
   logic        busy, error;
   logic [31:0] perf_ops, perf_cycles;

   int checks   = 0;
   int failures = 0;

   mule_issue_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req0_valid_i  (req0_valid),
      .req0_ra_i     (req0_ra),
      .req0_rb_i     (req0_rb),
      .req0_rd_idx_i (req0_rd),
      .req0_accept_o (req0_accept),
      .req1_valid_i  (req1_valid),
      .req1_ra_i     (req1_ra),
      .req1_rb_i     (req1_rb),
      .req1_rd_idx_i (req1_rd),
      .req1_accept_o (req1_accept),
      .flush_i       (flush),
      .mule_valid_o  (mule_valid),
      .mule_ra_o     (mule_ra),
      .mule_rb_o     (mule_rb),
      .mule_accept_i (mule_accept),
      .mule_done_i   (mule_done),
      .mule_value_i  (mule_value),
      .wb_valid_o    (wb_valid),
      .wb_pipe_o     (wb_pipe),
      .wb_rd_idx_o   (wb_rd),
      .wb_value_o    (wb_value),
      .busy_o        (busy),
      .error_o       (error),
      .perf_ops_o    (perf_ops),
      .perf_cycles_o (perf_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time bound in case something stalls.
   initial begin
      #1000000;
      $display("FAIL global_timeout: sim time exceeded, required completion");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        r0v;
      logic        r1v;
      logic [31:0] ra0;
      logic [31:0] rb0;
      logic [4:0]  rd0;
      logic [31:0] ra1;
      logic [31:0] rb1;
      logic [4:0]  rd1;
      int          bp;        // cycles mule_accept_i held low in ISSUE
      int          lat;       // WAIT cycles before the done cycle
      logic [31:0] val;
      logic        exp_pipe;
      logic [31:0] exp_ra;
      logic [31:0] exp_rb;
      logic [4:0]  exp_rd;
   } vec_t;

   vec_t vecs[7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      req0_valid  = 1'b0; req1_valid = 1'b0;
      req0_ra     = 32'd0; req0_rb = 32'd0; req0_rd = 5'd0;
      req1_ra     = 32'd0; req1_rb = 32'd0; req1_rd = 5'd0;
      flush       = 1'b0;
      mule_accept = 1'b0;
      mule_done   = 1'b0;
      mule_value  = 32'd0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Enter in an IDLE cycle (posedge+1). Leave in the writeback cycle with
   // requests dropped.
   task automatic run_vec(input int idx, input vec_t v);
      req0_valid = v.r0v; req0_ra = v.ra0; req0_rb = v.rb0; req0_rd = v.rd0;
      req1_valid = v.r1v; req1_ra = v.ra1; req1_rb = v.rb1; req1_rd = v.rd1;
      #1;
      chk("grant_acc0", 32'(req0_accept), 32'(!v.exp_pipe));
      chk("grant_acc1", 32'(req1_accept), 32'(v.exp_pipe));
      chk("grant_idle_busy", 32'(busy), 32'd0);
      step();
      for (int b = 0; b < v.bp; b++) begin
         #1;
         chk("bp_valid", 32'(mule_valid), 32'd1);
         chk("bp_ra", mule_ra, v.exp_ra);
         chk("bp_rb", mule_rb, v.exp_rb);
         chk("bp_no_accept", 32'(req0_accept | req1_accept), 32'd0);
         step();
      end
      mule_accept = 1'b1;
      #1;
      chk("issue_valid", 32'(mule_valid), 32'd1);
      chk("issue_ra", mule_ra, v.exp_ra);
      chk("issue_rb", mule_rb, v.exp_rb);
      chk("issue_busy", 32'(busy), 32'd1);
      step();
      mule_accept = 1'b0;
      for (int w = 0; w < v.lat; w++) begin
         #1;
         chk("wait_busy", 32'(busy), 32'd1);
         chk("wait_no_wb", 32'(wb_valid), 32'd0);
         chk("wait_valid_low", 32'(mule_valid), 32'd0);
         chk("wait_no_accept", 32'(req0_accept | req1_accept), 32'd0);
         step();
      end
      mule_done  = 1'b1;
      mule_value = v.val;
      #1;
      chk("done_busy", 32'(busy), 32'd1);
      step();
      mule_done  = 1'b0;
      mule_value = 32'd0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk("wb_valid", 32'(wb_valid), 32'd1);
      chk("wb_pipe", 32'(wb_pipe), 32'(v.exp_pipe));
      chk("wb_rd", 32'(wb_rd), 32'(v.exp_rd));
      chk("wb_value", wb_value, v.val);
      chk("wb_busy", 32'(busy), 32'd0);
      $display("op %0d: pipe=%0d rd=%0d value=%0h", idx, wb_pipe, wb_rd, wb_value);
   endtask

   int wb_seen;
   logic [31:0] exp_ops, exp_cycles;

   initial begin
      // r0v r1v ra0 rb0 rd0 ra1 rb1 rd1 bp lat val  exp_pipe exp_ra exp_rb exp_rd
      vecs[0] = '{1'b1, 1'b0, 32'd7, 32'd6, 5'd13, 32'd0, 32'd0, 5'd0,
                  0, 3, 32'd42, 1'b0, 32'd7, 32'd6, 5'd13};
      vecs[1] = '{1'b1, 1'b1, 32'd1, 32'd2, 5'd3, 32'd11, 32'd12, 5'd21,
                  0, 2, 32'h100, 1'b1, 32'd11, 32'd12, 5'd21};
      vecs[2] = '{1'b1, 1'b1, 32'd4, 32'd5, 5'd6, 32'd14, 32'd15, 5'd22,
                  0, 2, 32'h200, 1'b0, 32'd4, 32'd5, 5'd6};
      vecs[3] = '{1'b1, 1'b1, 32'hAAAA0000, 32'h5555, 5'd31, 32'hDEADBEEF, 32'hCAFEF00D, 5'd1,
                  0, 1, 32'hFFFFFFFF, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 5'd1};
      vecs[4] = '{1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 32'd9, 32'd10, 5'd7,
                  4, 1, 32'h5A, 1'b1, 32'd9, 32'd10, 5'd7};
      vecs[5] = '{1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 32'h20, 32'h30, 5'd2,
                  0, 0, 32'h600, 1'b1, 32'h20, 32'h30, 5'd2};
      vecs[6] = '{1'b1, 1'b1, 32'h77, 32'h88, 5'd17, 32'h99, 32'hAA, 5'd18,
                  0, 6, 32'h12345678, 1'b0, 32'h77, 32'h88, 5'd17};

      clear_inputs();
      do_reset();
      #1;
      chk("rst_mule_valid", 32'(mule_valid), 32'd0);
      chk("rst_mule_ra", mule_ra, 32'd0);
      chk("rst_mule_rb", mule_rb, 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_pipe", 32'(wb_pipe), 32'd0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      chk("rst_wb_value", wb_value, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_perf_ops", perf_ops, 32'd0);
      chk("rst_perf_cycles", perf_cycles, 32'd0);
      step();

      for (int i = 0; i < 7; i++) begin
         run_vec(i, vecs[i]);
         step();
      end

      // A done pulse while IDLE is ignored.
      mule_done = 1'b1; mule_value = 32'hBAD;
      step();
      mule_done = 1'b0;
      #1;
      chk("idle_done_no_wb", 32'(wb_valid), 32'd0);
      chk("idle_done_busy", 32'(busy), 32'd0);
      $display("seq idle_done: wb_valid=%0d", wb_valid);

      // Back-to-back: a new accept happens in the writeback cycle (3-cycle spacing).
      req0_valid = 1'b1; req0_ra = 32'd3; req0_rb = 32'd3; req0_rd = 5'd4;
      #1;
      chk("b2b_acc0", 32'(req0_accept), 32'd1);
      step();
      req0_valid = 1'b0; mule_accept = 1'b1;
      step();
      mule_accept = 1'b0; mule_done = 1'b1; mule_value = 32'd9;
      step();
      mule_done = 1'b0;
      req1_valid = 1'b1; req1_ra = 32'h1111; req1_rb = 32'h2222; req1_rd = 5'd9;
      #1;
      chk("b2b_wb0_valid", 32'(wb_valid), 32'd1);
      chk("b2b_wb0_value", wb_value, 32'd9);
      chk("b2b_acc1_in_wb", 32'(req1_accept), 32'd1);
      step();
      req1_valid = 1'b0; mule_accept = 1'b1;
      #1;
      chk("b2b_issue_ra", mule_ra, 32'h1111);
      step();
      mule_accept = 1'b0; mule_done = 1'b1; mule_value = 32'h77;
      step();
      mule_done = 1'b0;
      #1;
      chk("b2b_wb1_valid", 32'(wb_valid), 32'd1);
      chk("b2b_wb1_pipe", 32'(wb_pipe), 32'd1);
      chk("b2b_wb1_rd", 32'(wb_rd), 32'd9);
      $display("seq back_to_back: pipe=%0d rd=%0d value=%0h", wb_pipe, wb_rd, wb_value);
      step();

      // Flush in IDLE blocks the grant. Flush in ISSUE cancels, and a done in ISSUE is ignored.
      req0_valid = 1'b1; req0_ra = 32'h5; req0_rd = 5'd5; flush = 1'b1;
      #1;
      chk("flush_idle_no_acc", 32'(req0_accept), 32'd0);
      step();
      flush = 1'b0;
      #1;
      chk("flush_idle_still_idle", 32'(busy), 32'd0);
      chk("after_flush_acc0", 32'(req0_accept), 32'd1);
      step();
      req0_valid = 1'b0; flush = 1'b1; mule_done = 1'b1; mule_value = 32'hBEEF;
      #1;
      chk("flush_issue_valid", 32'(mule_valid), 32'd1);
      step();
      flush = 1'b0; mule_done = 1'b0;
      #1;
      chk("flush_issue_idle", 32'(busy), 32'd0);
      chk("flush_issue_valid_low", 32'(mule_valid), 32'd0);
      chk("flush_issue_no_wb", 32'(wb_valid), 32'd0);
      $display("seq flush_issue: busy=%0d mule_valid=%0d", busy, mule_valid);
      step();

      // Flush in WAIT: start accepted cycle 1, flush at cycle 3, done at cycle 6.
      req0_valid = 1'b1; req0_rd = 5'd12;
      step();                                   // cycle 1: ISSUE
      req0_valid = 1'b0; mule_accept = 1'b1;
      step();                                   // cycle 2: WAIT
      mule_accept = 1'b0;
      step();                                   // cycle 3: flush
      flush = 1'b1;
      step();                                   // cycle 4: DRAIN
      flush = 1'b0;
      #1;
      chk("drain_busy_c4", 32'(busy), 32'd1);
      chk("drain_no_wb_c4", 32'(wb_valid), 32'd0);
      step();                                   // cycle 5
      #1;
      chk("drain_busy_c5", 32'(busy), 32'd1);
      step();                                   // cycle 6: done
      mule_done = 1'b1; mule_value = 32'hD00D;
      #1;
      chk("drain_busy_c6", 32'(busy), 32'd1);
      step();                                   // cycle 7
      mule_done = 1'b0;
      #1;
      chk("drain_no_wb", 32'(wb_valid), 32'd0);
      chk("drain_idle", 32'(busy), 32'd0);
      $display("seq flush_wait: wb_valid=%0d busy=%0d", wb_valid, busy);
      step();

      // Flush coincident with done: the result is discarded.
      req1_valid = 1'b1; req1_rd = 5'd3;
      step();
      req1_valid = 1'b0; mule_accept = 1'b1;
      step();
      mule_accept = 1'b0; flush = 1'b1; mule_done = 1'b1; mule_value = 32'hF00;
      step();
      flush = 1'b0; mule_done = 1'b0;
      #1;
      chk("flush_done_no_wb", 32'(wb_valid), 32'd0);
      chk("flush_done_idle", 32'(busy), 32'd0);
      $display("seq flush_done: wb_valid=%0d busy=%0d", wb_valid, busy);
      step();

      // Watchdog: no done ever. error_o appears 8 cycles after WAIT entry.
      req0_valid = 1'b1; req0_rd = 5'd8;
      step();
      req0_valid = 1'b0; mule_accept = 1'b1;
      step();                                   // WAIT entry
      mule_accept = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("wd_no_error", 32'(error), 32'd0);
         chk("wd_busy", 32'(busy), 32'd1);
         chk("wd_no_wb", 32'(wb_valid), 32'd0);
         step();
      end
      #1;
      chk("wd_error_pulse", 32'(error), 32'd1);
      chk("wd_idle", 32'(busy), 32'd0);
      chk("wd_no_wb_abort", 32'(wb_valid), 32'd0);
      step();
      #1;
      chk("wd_error_once", 32'(error), 32'd0);
      $display("seq watchdog: error pulse seen, busy=%0d", busy);
      step();

      // Reset in the middle of WAIT. After reset, last_q=1, so pipe 0 wins a tie.
      req1_valid = 1'b1; req1_ra = 32'h1234; req1_rd = 5'd30;
      step();
      req1_valid = 1'b0; mule_accept = 1'b1;
      step();
      mule_accept = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_mule_valid", 32'(mule_valid), 32'd0);
      chk("midrst_mule_ra", mule_ra, 32'd0);
      chk("midrst_wb_rd", 32'(wb_rd), 32'd0);
      chk("midrst_error", 32'(error), 32'd0);
      step();
      mule_done = 1'b1; mule_value = 32'h4321;
      step();
      mule_done = 1'b0;
      #1;
      chk("midrst_late_done_no_wb", 32'(wb_valid), 32'd0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("midrst_tie_acc0", 32'(req0_accept), 32'd1);
      chk("midrst_tie_acc1", 32'(req1_accept), 32'd0);
      $display("seq mid_reset: busy=%0d", busy);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Perf run: 1000 back-to-back ops, each with 4 WAIT cycles.
      clear_inputs();
      do_reset();
      wb_seen = 0;
      req0_valid = 1'b1; req0_rd = 5'd1;
      mule_accept = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         step();                                // ISSUE
         step();                                // W1
         step();                                // W2
         step();                                // W3
         step();                                // W4
         mule_done = 1'b1; mule_value = 32'(i);
         step();                                // writeback cycle
         mule_done = 1'b0;
         if (i == 999) req0_valid = 1'b0;
         #1;
         if (wb_valid === 1'b1) wb_seen++;
         if (i == 500) begin
`ifdef MULE_ARB_PERF_EN
            exp_ops = 32'd500; exp_cycles = 32'd2505;
`else
            exp_ops = 32'd0; exp_cycles = 32'd0;
`endif
            chk("perf_mid_ops", perf_ops, exp_ops);
            chk("perf_mid_cycles", perf_cycles, exp_cycles);
            chk("perf_mid_wb_value", wb_value, 32'd500);
         end
      end
      mule_accept = 1'b0;
      step();
`ifdef MULE_ARB_PERF_EN
      exp_ops = 32'd1000; exp_cycles = 32'd5000;
`else
      exp_ops = 32'd0; exp_cycles = 32'd0;
`endif
      chk("perf_wb_seen", 32'(wb_seen), 32'd1000);
      chk("perf_ops", perf_ops, exp_ops);
      chk("perf_cycles", perf_cycles, exp_cycles);
      chk("perf_end_idle", 32'(busy), 32'd0);
      $display("seq perf: ops=%0d cycles=%0d wb_seen=%0d", perf_ops, perf_cycles, wb_seen);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
